qpi_memory_master: RTL and testbench

- Initiator side of the team's SPI/dual/quad memory link; drives sck/cs/io into a qpi_memory_slave or a compatible serial memory.
- A host issues one transaction at a time: command, address, optional dummy cycles, then an N-byte data burst (write or read).
- SCK is mode 0 (CPOL=0, CPHA=0) and is generated by dividing main_clock.

---
 rtl/qpi_pkg.sv | 55 +++++
 rtl/qpi_sck_gen.sv | 40 ++++
 rtl/qpi_memory_master.sv | 209 ++++++++++++++++++++
 tb/tb_qpi_memory_master.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qpi_pkg.sv
// Shared definitions for the serial memory link: opcodes, lane modes, FSM states
// and small helpers used by both ends of the link.
package qpi_pkg;

    typedef enum logic [1:0] {
        MODE_SINGLE = 2'd0,
        MODE_DOUBLE = 2'd1,
        MODE_QUAD   = 2'd2
    } qpi_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE, ST_SETUP, ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA, ST_HOLD, ST_GAP
    } qpi_state_e;

    localparam logic [7:0] OP_WRITE_SINGLE = 8'h02;
    localparam logic [7:0] OP_READ_SINGLE  = 8'h03;
    localparam logic [7:0] OP_WRITE_DUAL   = 8'h3A;
    localparam logic [7:0] OP_READ_DUAL    = 8'h3B;
    localparam logic [7:0] OP_WRITE_QUAD   = 8'h38;
    localparam logic [7:0] OP_READ_QUAD    = 8'hEB;

    // Encoding 3 is reserved and falls back to single-lane operation.
    function automatic qpi_mode_e norm_mode(input logic [1:0] m);
        case (m)
            2'd1:    return MODE_DOUBLE;
            2'd2:    return MODE_QUAD;
            default: return MODE_SINGLE;
        endcase
    endfunction

    function automatic logic [7:0] opcode_for(input logic wr, input qpi_mode_e m);
        case (m)
            MODE_DOUBLE: return wr ? OP_WRITE_DUAL : OP_READ_DUAL;
            MODE_QUAD:   return wr ? OP_WRITE_QUAD : OP_READ_QUAD;
            default:     return wr ? OP_WRITE_SINGLE : OP_READ_SINGLE;
        endcase
    endfunction

    function automatic logic [3:0] cycles_per_byte(input qpi_mode_e m);
        case (m)
            MODE_DOUBLE: return 4'd4;
            MODE_QUAD:   return 4'd2;
            default:     return 4'd8;
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input qpi_mode_e m);
        case (m)
            MODE_DOUBLE: return 4'b0011;
            MODE_QUAD:   return 4'b1111;
            default:     return 4'b0001;
        endcase
    endfunction

endpackage

// File: rtl/qpi_sck_gen.sv
// Mode-0 serial clock divider: sck toggles every CLK_DIV enabled cycles and the
// rise/fall strobes flag the cycle on which sck is about to change.
module qpi_sck_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic sck_o,
    output logic rise_o,
    output logic fall_o
);
    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt_q;
    logic          sck_q;
    logic          tick;

    assign tick   = en_i && (cnt_q == CW'(CLK_DIV - 1));
    assign rise_o = tick && !sck_q;
    assign fall_o = tick && sck_q;
    assign sck_o  = sck_q;

    // Disabling parks sck low and restarts the half-period from zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            sck_q <= 1'b0;
        end else if (!en_i) begin
            cnt_q <= '0;
            sck_q <= 1'b0;
        end else if (tick) begin
            cnt_q <= '0;
            sck_q <= ~sck_q;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/qpi_memory_master.sv
// Serial memory initiator: one transaction of command, address, optional dummy
// cycles and an N-byte single/dual/quad data burst per accepted start.
module qpi_memory_master
    import qpi_pkg::*;
#(
    parameter int ADDR_BYTES        = 3,
    parameter int READ_DUMMY_CYCLES = 8,
    parameter int CLK_DIV           = 4,
    parameter int CS_GAP            = 4,
    parameter int LEN_W             = 16
) (
    input  logic                    main_clock,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    cmd_write,
    input  logic [1:0]              cmd_mode,
    input  logic [ADDR_BYTES*8-1:0] cmd_addr,
    input  logic [LEN_W-1:0]        cmd_len,
    output logic                    busy,
    output logic                    done,
    input  logic [7:0]              wr_data,
    output logic                    wr_data_req,
    output logic [7:0]              rd_data,
    output logic                    rd_valid,
    output logic                    sck,
    output logic                    cs,
    inout  wire  [3:0]              io
);
    localparam int AW    = ADDR_BYTES * 8;
    localparam int SW    = 8 + AW;
    localparam int CNT_W = 16;

    qpi_state_e        state_q;
    qpi_mode_e         mode_q;
    logic              cs_q, busy_q, done_q, wr_req_q, rd_valid_q, write_q, sck_en_q;
    logic [7:0]        rd_data_q, dsh_q;
    logic [SW-1:0]     sh_q;
    logic [LEN_W-1:0]  len_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [3:0]        cyc_q, oe_q, out_bits, cpb;
    logic [7:0]        rd_next, wr_shift;
    logic              sck_rise, sck_fall;

    qpi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck (
        .clk    (main_clock),
        .rst_n  (reset_n),
        .en_i   (sck_en_q),
        .sck_o  (sck),
        .rise_o (sck_rise),
        .fall_o (sck_fall)
    );

    assign cpb = cycles_per_byte(mode_q);

    always_comb begin
        out_bits = {3'b000, sh_q[SW-1]};
        rd_next  = {dsh_q[6:0], io[1]};
        wr_shift = {dsh_q[6:0], 1'b0};
        if (state_q == ST_DATA || state_q == ST_HOLD) begin
            case (mode_q)
                MODE_QUAD:   out_bits = dsh_q[7:4];
                MODE_DOUBLE: out_bits = {2'b00, dsh_q[7:6]};
                default:     out_bits = {3'b000, dsh_q[7]};
            endcase
        end
        case (mode_q)
            MODE_QUAD: begin
                rd_next  = {dsh_q[3:0], io[3:0]};
                wr_shift = {dsh_q[3:0], 4'h0};
            end
            MODE_DOUBLE: begin
                rd_next  = {dsh_q[5:0], io[1:0]};
                wr_shift = {dsh_q[5:0], 2'b00};
            end
            default: ;
        endcase
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_io
        assign io[gi] = oe_q[gi] ? out_bits[gi] : 1'bz;
    end

    always_ff @(posedge main_clock) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_SINGLE;
            cs_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wr_req_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            write_q    <= 1'b0;
            sck_en_q   <= 1'b0;
            dsh_q      <= '0;
            sh_q       <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            cyc_q      <= '0;
            oe_q       <= '0;
        end else begin
            done_q     <= 1'b0;
            wr_req_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: if (start && cmd_len != '0) begin
                    write_q <= cmd_write;
                    mode_q  <= norm_mode(cmd_mode);
                    sh_q    <= {opcode_for(cmd_write, norm_mode(cmd_mode)), cmd_addr};
                    len_q   <= cmd_len;
                    busy_q  <= 1'b1;
                    cs_q    <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= ST_SETUP;
                end
                ST_SETUP: if (cnt_q == CNT_W'(CS_GAP - 1)) begin
                    cnt_q    <= '0;
                    sck_en_q <= 1'b1;
                    oe_q     <= 4'b0001;
                    state_q  <= ST_CMD;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                // Command and address share one shift register; only the bit count differs.
                ST_CMD, ST_ADDR: if (sck_fall) begin
                    sh_q <= sh_q << 1;
                    if (state_q == ST_CMD && cnt_q == CNT_W'(7)) begin
                        cnt_q   <= '0;
                        state_q <= ST_ADDR;
                    end else if (state_q == ST_ADDR && cnt_q == CNT_W'(AW - 1)) begin
                        cnt_q <= '0;
                        cyc_q <= '0;
                        if (write_q) begin
                            dsh_q    <= wr_data;
                            wr_req_q <= 1'b1;
                            oe_q     <= lane_mask(mode_q);
                            state_q  <= ST_DATA;
                        end else begin
                            oe_q    <= '0;
                            state_q <= (READ_DUMMY_CYCLES == 0) ? ST_DATA : ST_DUMMY;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DUMMY: if (sck_fall) begin
                    if (cnt_q == CNT_W'(READ_DUMMY_CYCLES - 1)) begin
                        cnt_q   <= '0;
                        state_q <= ST_DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (sck_rise && !write_q) begin
                        dsh_q <= rd_next;
                        if (cyc_q == cpb - 4'd1) begin
                            rd_data_q  <= rd_next;
                            rd_valid_q <= 1'b1;
                        end
                    end
                    // Byte boundaries are taken on the falling edge so sck always ends low.
                    if (sck_fall) begin
                        if (cyc_q == cpb - 4'd1) begin
                            cyc_q <= '0;
                            len_q <= len_q - 1'b1;
                            if (len_q == LEN_W'(1)) begin
                                sck_en_q <= 1'b0;
                                cnt_q    <= '0;
                                state_q  <= ST_HOLD;
                            end else if (write_q) begin
                                dsh_q    <= wr_data;
                                wr_req_q <= 1'b1;
                            end
                        end else begin
                            cyc_q <= cyc_q + 1'b1;
                            if (write_q) dsh_q <= wr_shift;
                        end
                    end
                end
                ST_HOLD: if (cnt_q == CNT_W'(CS_GAP - 1)) begin
                    cnt_q   <= '0;
                    cs_q    <= 1'b1;
                    done_q  <= 1'b1;
                    oe_q    <= '0;
                    state_q <= ST_GAP;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                ST_GAP: if (cnt_q == CNT_W'(CS_GAP - 1)) begin
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cs          = cs_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign wr_data_req = wr_req_q;
    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;

endmodule

// File: tb/tb_qpi_memory_master.sv
// Directed bench for qpi_memory_master with a behavioural serial slave that
// captures every rising-SCK io value and serves read data on falling SCK.
module tb_qpi_memory_master;
    localparam int RD_DUMMY = 8;
    localparam int CS_GAP   = 4;

    logic        main_clock = 1'b0;
    logic        reset_n    = 1'b0;
    logic        start      = 1'b0;
    logic        cmd_write  = 1'b0;
    logic [1:0]  cmd_mode   = 2'd0;
    logic [23:0] cmd_addr   = '0;
    logic [15:0] cmd_len    = '0;
    logic [7:0]  wr_data    = '0;
    wire         busy, done, wr_data_req, rd_valid, sck, cs;
    wire  [7:0]  rd_data;
    wire  [3:0]  io;
    logic [3:0]  tb_out = '0;
    logic [3:0]  tb_oe  = '0;

    for (genvar gi = 0; gi < 4; gi++) begin : g_slv_io
        assign io[gi] = tb_oe[gi] ? tb_out[gi] : 1'bz;
    end

    always #5 main_clock = ~main_clock;

    qpi_memory_master #(
        .ADDR_BYTES(3), .READ_DUMMY_CYCLES(RD_DUMMY), .CLK_DIV(4), .CS_GAP(CS_GAP), .LEN_W(16)
    ) dut (
        .main_clock (main_clock), .reset_n (reset_n), .start (start),
        .cmd_write (cmd_write), .cmd_mode (cmd_mode), .cmd_addr (cmd_addr),
        .cmd_len (cmd_len), .busy (busy), .done (done), .wr_data (wr_data),
        .wr_data_req (wr_data_req), .rd_data (rd_data), .rd_valid (rd_valid),
        .sck (sck), .cs (cs), .io (io)
    );

    int tests = 0;
    int fails = 0;
    int rise_cnt = 0, fall_cnt = 0, done_cnt = 0, req_cnt = 0, rd_cnt = 0, wr_idx = 0;
    int cs_high_run = 0, min_gap = 1000;
    int slv_bpc = 1;
    logic slv_read = 1'b0;
    logic oe_after_addr = 1'b0;
    logic [3:0] cap [0:255];
    logic [7:0] rd_got [0:15];
    logic [7:0] wr_src [0:15];
    logic [7:0] slv_bytes [0:15];

    always @(posedge sck) begin
        if (!cs) begin
            if (rise_cnt < 256) cap[rise_cnt] = io;
            rise_cnt++;
        end
    end

    // Slave presents read data after the last dummy falling edge, one chunk per SCK.
    always @(negedge sck) begin : slv_drive
        int k;
        logic [7:0] b;
        if (!cs) begin
            fall_cnt++;
            k = rise_cnt - (32 + RD_DUMMY);
            if (slv_read && k >= 0 && k < 64) begin
                case (slv_bpc)
                    4: begin
                        b = slv_bytes[k / 2];
                        tb_out = (k % 2 == 0) ? b[7:4] : b[3:0];
                        tb_oe  = 4'hF;
                    end
                    2: begin
                        b = slv_bytes[k / 4] << (2 * (k % 4));
                        tb_out = {2'b00, b[7:6]};
                        tb_oe  = 4'b0011;
                    end
                    default: begin
                        b = slv_bytes[k / 8] << (k % 8);
                        tb_out = {2'b00, b[7], 1'b0};
                        tb_oe  = 4'b0010;
                    end
                endcase
            end
        end
    end

    always @(posedge cs) tb_oe = '0;

    always @(negedge main_clock) begin
        if (done) done_cnt++;
        if (wr_data_req) begin
            req_cnt++;
            if (wr_idx < 15) wr_idx++;
            wr_data = wr_src[wr_idx];
        end
        if (rd_valid) begin
            if (rd_cnt < 16) rd_got[rd_cnt] = rd_data;
            rd_cnt++;
        end
        if (!cs && slv_read && fall_cnt >= 32 && dut.oe_q != 4'b0000) oe_after_addr = 1'b1;
        if (cs) cs_high_run++;
        else begin
            if (cs_high_run > 0 && cs_high_run < min_gap) min_gap = cs_high_run;
            cs_high_run = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
        $display("[TB] check %-14s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] cap_opcode();
        logic [7:0] v = '0;
        for (int i = 0; i < 8; i++) v = {v[6:0], cap[i][0]};
        return v;
    endfunction

    function automatic logic [23:0] cap_addr();
        logic [23:0] v = '0;
        for (int i = 8; i < 32; i++) v = {v[22:0], cap[i][0]};
        return v;
    endfunction

    function automatic logic [7:0] cap_byte(input int j, input int bpc);
        logic [7:0] v = '0;
        logic [3:0] c;
        int n = 8 / bpc;
        for (int i = 0; i < n; i++) begin
            c = cap[32 + j * n + i];
            case (bpc)
                4:       v = {v[3:0], c};
                2:       v = {v[5:0], c[1:0]};
                default: v = {v[6:0], c[0]};
            endcase
        end
        return v;
    endfunction

    task automatic launch(input logic wr, input logic [1:0] mode, input logic [23:0] addr,
                          input logic [15:0] len);
        rise_cnt = 0; fall_cnt = 0; done_cnt = 0; req_cnt = 0; rd_cnt = 0; wr_idx = 0;
        oe_after_addr = 1'b0;
        wr_data = wr_src[0];
        @(negedge main_clock);
        cmd_write = wr; cmd_mode = mode; cmd_addr = addr; cmd_len = len; start = 1'b1;
        @(negedge main_clock);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 5000) begin
            @(negedge main_clock);
            n++;
        end
        chk(tag, 32'(n < 5000), 32'd1);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge main_clock);
        chk("rst_cs", 32'(cs), 32'd1);
        chk("rst_sck", 32'(sck), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_oe", 32'(dut.oe_q), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge main_clock);

        // Single write A5,3C at 0x012345
        wr_src[0] = 8'hA5; wr_src[1] = 8'h3C; wr_src[2] = 8'h00;
        launch(1'b1, 2'd0, 24'h012345, 16'd2);
        wait_idle("sw_timeout");
        chk("sw_opcode", 32'(cap_opcode()), 32'h02);
        chk("sw_addr", 32'(cap_addr()), 32'h012345);
        chk("sw_byte0", 32'(cap_byte(0, 1)), 32'hA5);
        chk("sw_byte1", 32'(cap_byte(1, 1)), 32'h3C);
        chk("sw_edges", 32'(rise_cnt), 32'd48);
        chk("sw_reqs", 32'(req_cnt), 32'd2);
        chk("sw_done", 32'(done_cnt), 32'd1);

        // Quad read EB at 0x000010, slave returns 11,22,33
        slv_read = 1'b1; slv_bpc = 4;
        slv_bytes[0] = 8'h11; slv_bytes[1] = 8'h22; slv_bytes[2] = 8'h33;
        launch(1'b0, 2'd2, 24'h000010, 16'd3);
        wait_idle("qr_timeout");
        chk("qr_opcode", 32'(cap_opcode()), 32'hEB);
        chk("qr_addr", 32'(cap_addr()), 32'h000010);
        chk("qr_edges", 32'(rise_cnt), 32'd46);
        chk("qr_rdcnt", 32'(rd_cnt), 32'd3);
        chk("qr_rd0", 32'(rd_got[0]), 32'h11);
        chk("qr_rd1", 32'(rd_got[1]), 32'h22);
        chk("qr_rd2", 32'(rd_got[2]), 32'h33);
        chk("qr_master_oe", 32'(oe_after_addr), 32'd0);
        chk("qr_done", 32'(done_cnt), 32'd1);
        slv_read = 1'b0;

        // Dual write C6: io[1:0] = 11,00,01,10
        wr_src[0] = 8'hC6;
        launch(1'b1, 2'd1, 24'h00ABCD, 16'd1);
        wait_idle("dw_timeout");
        chk("dw_opcode", 32'(cap_opcode()), 32'h3A);
        chk("dw_pair0", 32'(cap[32][1:0]), 32'd3);
        chk("dw_pair1", 32'(cap[33][1:0]), 32'd0);
        chk("dw_pair2", 32'(cap[34][1:0]), 32'd1);
        chk("dw_pair3", 32'(cap[35][1:0]), 32'd2);
        chk("dw_edges", 32'(rise_cnt), 32'd36);
        chk("dw_reqs", 32'(req_cnt), 32'd1);

        // start with cmd_len=0 is ignored
        launch(1'b1, 2'd0, 24'h000001, 16'd0);
        repeat (20) @(negedge main_clock);
        chk("len0_cs", 32'(cs), 32'd1);
        chk("len0_busy", 32'(busy), 32'd0);
        chk("len0_edges", 32'(rise_cnt), 32'd0);

        // start while busy is ignored
        wr_src[0] = 8'h5A;
        launch(1'b1, 2'd0, 24'h000100, 16'd1);
        repeat (50) @(negedge main_clock);
        cmd_addr = 24'hFFFFFF; cmd_len = 16'd7; start = 1'b1;
        @(negedge main_clock);
        start = 1'b0;
        chk("busy_cs", 32'(cs), 32'd0);
        wait_idle("busy_timeout");
        repeat (30) @(negedge main_clock);
        chk("busy_edges", 32'(rise_cnt), 32'd40);
        chk("busy_addr", 32'(cap_addr()), 32'h000100);
        chk("busy_done", 32'(done_cnt), 32'd1);
        chk("busy_idle", 32'(busy), 32'd0);

        // Reset in the middle of a single read
        slv_read = 1'b1; slv_bpc = 1;
        slv_bytes[0] = 8'h5A; slv_bytes[1] = 8'hC3; slv_bytes[2] = 8'h0F; slv_bytes[3] = 8'hF0;
        launch(1'b0, 2'd0, 24'h000200, 16'd4);
        begin
            int n = 0;
            while (rd_cnt < 1 && n < 2000) begin
                @(negedge main_clock);
                n++;
            end
            chk("mr_wait", 32'(n < 2000), 32'd1);
        end
        chk("mr_rd0", 32'(rd_got[0]), 32'h5A);
        reset_n = 1'b0;
        @(negedge main_clock);
        chk("mr_cs", 32'(cs), 32'd1);
        chk("mr_sck", 32'(sck), 32'd0);
        chk("mr_oe", 32'(dut.oe_q), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge main_clock);
        chk("mr_nodone", 32'(done_cnt), 32'd0);
        reset_n = 1'b1;
        slv_bytes[0] = 8'h96;
        launch(1'b0, 2'd0, 24'h000300, 16'd1);
        wait_idle("mr2_timeout");
        chk("mr2_rd0", 32'(rd_got[0]), 32'h96);
        chk("mr2_rdcnt", 32'(rd_cnt), 32'd1);
        chk("mr2_edges", 32'(rise_cnt), 32'd48);
        chk("mr2_done", 32'(done_cnt), 32'd1);
        slv_read = 1'b0;

        // Back-to-back single writes
        min_gap = 1000;
        wr_src[0] = 8'h81;
        launch(1'b1, 2'd0, 24'h000400, 16'd1);
        wait_idle("bb1_timeout");
        chk("bb1_byte", 32'(cap_byte(0, 1)), 32'h81);
        chk("bb1_addr", 32'(cap_addr()), 32'h000400);
        wr_src[0] = 8'h7E;
        launch(1'b1, 2'd0, 24'h000401, 16'd1);
        wait_idle("bb2_timeout");
        chk("bb2_byte", 32'(cap_byte(0, 1)), 32'h7E);
        chk("bb2_addr", 32'(cap_addr()), 32'h000401);
        chk("bb_gap_ok", 32'(min_gap >= CS_GAP), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
